// File: rtl/bary_pkg.sv
// bary_pkg: shared constants and FSM state type for barycentric_interp.
// Saturation on the result is selected by defining BARY_INTERP_SAT_EN.
package bary_pkg;
    localparam int DEF_COORD_WIDTH = 32;
    localparam int FRAC_BITS = DEF_COORD_WIDTH / 2;
    localparam logic [DEF_COORD_WIDTH-1:0] FP_ONE =
        DEF_COORD_WIDTH'(1) << FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        LOAD,
        RUN
    } state_t;
endpackage

// File: rtl/bary_mac_lane.sv
// bary_mac_lane: one component of p = u*a + v*b + w*c, three stages.
// BARY_INTERP_SAT_EN selects clamping with ovf, otherwise wrap with ovf=0.
module bary_mac_lane
    import bary_pkg::*;
#(
    parameter int W = DEF_COORD_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_s1,
    input  logic                en_s2,
    input  logic                en_s3,
    input  logic signed [W-1:0] u,
    input  logic signed [W-1:0] v,
    input  logic signed [W-1:0] w,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    output logic signed [W-1:0] p,
    output logic                ovf
);
    localparam int FRAC = W / 2;
    localparam int PW = 2 * W;
    localparam int SW = 2 * W + 2;
`ifdef BARY_INTERP_SAT_EN
    localparam int SH = SW - FRAC;
`else
    localparam int SH = W;
`endif

    logic signed [PW-1:0] pa, pb, pc;
    logic signed [SH-1:0] s2;

    // S1: the three full-precision products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa <= '0;
            pb <= '0;
            pc <= '0;
        end else if (en_s1) begin
            pa <= PW'(u) * PW'(a);
            pb <= PW'(v) * PW'(b);
            pc <= PW'(w) * PW'(c);
        end
    end

    // S2: widened sum, then drop FRAC bits rounding toward -inf
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2 <= '0;
        end else if (en_s2) begin
            s2 <= SH'((SW'(pa) + SW'(pb) + SW'(pc)) >>> FRAC);
        end
    end

`ifdef BARY_INTERP_SAT_EN
    logic fits;
    assign fits = (&s2[SH-1:W-1]) | ~(|s2[SH-1:W-1]);

    // S3: clamp out-of-range sums and flag the beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p   <= '0;
            ovf <= 1'b0;
        end else if (en_s3) begin
            if (fits) begin
                p   <= s2[W-1:0];
                ovf <= 1'b0;
            end else if (s2[SH-1]) begin
                p   <= {1'b1, {(W-1){1'b0}}};
                ovf <= 1'b1;
            end else begin
                p   <= {1'b0, {(W-1){1'b1}}};
                ovf <= 1'b1;
            end
        end
    end
`else
    assign ovf = 1'b0;

    // S3: keep the low W bits (two's-complement wrap)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else if (en_s3) begin
            p <= s2;
        end
    end
`endif
endmodule

// File: rtl/barycentric_interp.sv
// barycentric_interp: streams weights (u,v,w) against a latched triangle.
// Result saturation is enabled by defining BARY_INTERP_SAT_EN.
module barycentric_interp
    import bary_pkg::*;
#(
    parameter int COORD_WIDTH = DEF_COORD_WIDTH,
    parameter int N_ATTR = 3
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                init,
    input  logic [N_ATTR-1:0][COORD_WIDTH-1:0]  a,
    input  logic [N_ATTR-1:0][COORD_WIDTH-1:0]  b,
    input  logic [N_ATTR-1:0][COORD_WIDTH-1:0]  c,
    output logic                                init_done,
    input  logic signed [COORD_WIDTH-1:0]       u,
    input  logic signed [COORD_WIDTH-1:0]       v,
    input  logic signed [COORD_WIDTH-1:0]       w,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [N_ATTR-1:0][COORD_WIDTH-1:0]  p,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                ovf
);
    localparam int W = COORD_WIDTH;

    state_t state;
    logic [N_ATTR-1:0][W-1:0] va, vb, vc;
    logic signed [W-1:0] s0_u, s0_v, s0_w;
    logic v0, v1, v2;
    logic stall, adv, accept, inflight, busy;
    logic [N_ATTR-1:0] lane_ovf;

    assign stall    = out_valid && !out_ready;
    assign adv      = !stall;
    assign in_ready = (state == RUN) && adv;
    assign accept   = in_valid && in_ready;
    assign inflight = v0 | v1 | v2 | out_valid;
    assign busy     = inflight | accept;

    // Triangle-load sequencing; init_done marks the LOAD->RUN step
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b0;
            unique case (state)
                IDLE:  if (init) state <= LOAD;
                RUN:   if (init) state <= busy ? DRAIN : LOAD;
                DRAIN: if (!inflight) state <= LOAD;
                LOAD: begin
                    state     <= RUN;
                    init_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Vertex registers, sampled only in the LOAD cycle
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            va <= '0;
            vb <= '0;
            vc <= '0;
        end else if (state == LOAD) begin
            va <= a;
            vb <= b;
            vc <= c;
        end
    end

    // Input register for accepted weights
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s0_u <= '0;
            s0_v <= '0;
            s0_w <= '0;
        end else if (accept) begin
            s0_u <= u;
            s0_v <= v;
            s0_w <= w;
        end
    end

    // Valid chain; everything freezes while the output is stalled
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            v0        <= accept;
            v1        <= v0;
            v2        <= v1;
            out_valid <= v2;
        end
    end

    for (genvar i = 0; i < N_ATTR; i++) begin : g_lane
        bary_mac_lane #(.W(W)) u_lane (
            .clk   (clk_in),
            .rst_n (rst_in),
            .en_s1 (adv && v0),
            .en_s2 (adv && v1),
            .en_s3 (adv && v2),
            .u     (s0_u),
            .v     (s0_v),
            .w     (s0_w),
            .a     (va[i]),
            .b     (vb[i]),
            .c     (vc[i]),
            .p     (p[i]),
            .ovf   (lane_ovf[i])
        );
    end

    assign ovf = |lane_ovf;
endmodule

// File: tb/tb_barycentric_interp.sv
// tb_barycentric_interp: directed + random checks against a wide-integer model.
// Honours BARY_INTERP_SAT_EN in the expected-value model.
module tb_barycentric_interp;
    localparam int W = 32;
    localparam int N = 3;
    localparam int F = 16;
    localparam logic signed [127:0] MAXV = 128'sh7FFF_FFFF;
    localparam logic signed [127:0] MINV = -128'sh8000_0000;

    typedef logic [N-1:0][W-1:0] vec_t;
    typedef struct packed {
        logic [N*W-1:0] p;
        logic           o;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic init = 1'b0;
    logic init_done, in_ready, out_valid, ovf;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    vec_t a = '0, b = '0, c = '0, p;
    logic [W-1:0] u = '0, v = '0, w = '0;

    exp_t exp_q[$];
    vec_t ta = '0, tb_ = '0, tc = '0;
    int n_checks = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, n_out = 0;
    int out_cyc[$];
    logic [N*W-1:0] last_p = '0;
    logic last_o = 1'b0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    barycentric_interp #(.COORD_WIDTH(W), .N_ATTR(N)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .init      (init),
        .a         (a),
        .b         (b),
        .c         (c),
        .init_done (init_done),
        .u         (u),
        .v         (v),
        .w         (w),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] uu, vv, ww,
                                   input vec_t aa, bb, cc);
        exp_t e;
        logic signed [127:0] s;
        e.p = '0;
        e.o = 1'b0;
        for (int i = 0; i < N; i++) begin
            s = 128'($signed(uu)) * 128'($signed(aa[i]))
              + 128'($signed(vv)) * 128'($signed(bb[i]))
              + 128'($signed(ww)) * 128'($signed(cc[i]));
            s = s >>> F;
`ifdef BARY_INTERP_SAT_EN
            if (s > MAXV) begin
                e.p[i*W +: W] = 32'h7FFF_FFFF;
                e.o = 1'b1;
            end else if (s < MINV) begin
                e.p[i*W +: W] = 32'h8000_0000;
                e.o = 1'b1;
            end else begin
                e.p[i*W +: W] = s[W-1:0];
            end
`else
            e.p[i*W +: W] = s[W-1:0];
`endif
        end
        return e;
    endfunction

    function automatic vec_t vec3(input logic [W-1:0] x0, x1, x2);
        vec_t r;
        r[0] = x0;
        r[1] = x1;
        r[2] = x2;
        return r;
    endfunction

    function automatic vec_t rnd_vec();
        return vec3($urandom, $urandom, $urandom);
    endfunction

    // Scoreboard: record accepts, compare every output handshake
    always @(negedge clk_in) begin : mon
        exp_t e;
        if (rst_in) begin
            if (in_valid && in_ready)
                exp_q.push_back(model(u, v, w, ta, tb_, tc));
            if (out_valid && out_ready) begin
                n_out++;
                out_cyc.push_back(cyc);
                last_p = p;
                last_o = ovf;
                chk("sb_has_entry", 128'(exp_q.size() > 0), 128'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("p", p, e.p);
                    chk("ovf", ovf, e.o);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic load(input vec_t na, nb, nc, input bit fast,
                        input bit with_beat);
        bit got;
        int lat;
        a = na;
        b = nb;
        c = nc;
        init = 1'b1;
        @(negedge clk_in);
        if (with_beat) chk("beat_with_init_ready", in_ready, 1);
        tick();
        init = 1'b0;
        in_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk_in);
            if (init_done) begin
                got = 1'b1;
                lat = i;
            end
        end
        chk("init_done_seen", got, 1);
        if (got) chk("ready_at_init_done", in_ready, 1);
        if (fast) chk("init_done_latency", lat, 2);
        ta = na;
        tb_ = nb;
        tc = nc;
        tick();
    endtask

    task automatic send(input logic [W-1:0] nu, nv, nw);
        bit ok;
        u = nu;
        v = nv;
        w = nw;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_in);
            if (in_ready) ok = 1'b1;
        end
        chk("accept", ok, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_in);
            if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
        end
        chk("drain", ok, 1);
        tick();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        vec_t t1;
        bit early, stale, rdy;
        int n0;

        // reset values
        #1 rst_in = 1'b0;
        #1;
        chk("rst_p", p, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_ovf", ovf, 0);
        tick();
        tick();
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("idle_not_ready", in_ready, 0);
        tick();

        // basic triangle, first results and latency
        t1 = vec3(32'h0, 32'h0, 32'h0);
        load(t1, vec3(32'h000A_0000, 0, 0), vec3(0, 32'h000A_0000, 0), 1, 0);
        send(32'h1_0000, 0, 0);
        drain();
        chk("u_one_p", last_p, 0);
        send(0, 32'h8000, 32'h8000);
        early = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            if (k < 3) early |= out_valid;
            else begin
                chk("lat_early", early, 0);
                chk("lat_t3_valid", out_valid, 1);
                chk("lat_t3_p", p, {32'h0, 32'h0005_0000, 32'h0005_0000});
            end
        end
        tick();
        drain();

        // 8 back-to-back beats, one result per cycle
        out_cyc.delete();
        for (int k = 0; k < 8; k++)
            send($urandom_range(0, 32'h1_0000), $urandom_range(0, 32'h1_0000),
                 $urandom_range(0, 32'h1_0000));
        drain();
        chk("b2b_count", out_cyc.size(), 8);
        if (out_cyc.size() == 8)
            chk("b2b_span", out_cyc[7] - out_cyc[0], 7);

        // output stall with 4 beats in flight
        n0 = n_out;
        for (int k = 0; k < 4; k++)
            send($urandom_range(0, 32'h2_0000), $urandom, $urandom_range(0, 255));
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            if (exp_q.size() > 0) chk("stall_p_held", p, exp_q[0].p);
        end
        tick();
        out_ready = 1'b1;
        drain();
        chk("stall_delivered", n_out - n0, 4);

        // re-init with 2 beats in flight, new c
        send($urandom_range(0, 32'h1_0000), $urandom_range(0, 32'h1_0000), 32'h1_0000);
        send(32'h4000, 32'h4000, 32'h8000);
        load(t1, vec3(32'h000A_0000, 0, 0), vec3(0, 32'h0014_0000, 0), 0, 0);
        chk("drained_before_done", exp_q.size(), 0);
        send(0, 0, 32'h1_0000);
        drain();
        chk("new_c_p", last_p, {32'h0, 32'h0014_0000, 32'h0});

        // init together with a beat, then overflow case
        u = $urandom_range(0, 32'h1_0000);
        v = $urandom_range(0, 32'h1_0000);
        w = $urandom_range(0, 32'h1_0000);
        in_valid = 1'b1;
        load(vec3(32'h7FFF_0000, 0, 0), vec3(0, 0, 0), vec3(0, 0, 0), 0, 1);
        send(32'h2_0000, 0, 0);
        drain();
`ifdef BARY_INTERP_SAT_EN
        chk("ovf_p0", last_p[31:0], 32'h7FFF_FFFF);
        chk("ovf_flag", last_o, 1);
`else
        chk("wrap_p0", last_p[31:0], 32'hFFFE_0000);
        chk("wrap_flag", last_o, 0);
`endif

        // fully random triangle and weights
        load(rnd_vec(), rnd_vec(), rnd_vec(), 1, 0);
        for (int k = 0; k < 12; k++) send($urandom, $urandom, $urandom);
        drain();

        // reset mid-stream
        for (int k = 0; k < 3; k++) send($urandom, $urandom, $urandom);
        #2 rst_in = 1'b0;
        #1;
        chk("mid_rst_p", p, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_ovf", ovf, 0);
        exp_q.delete();
        tick();
        tick();
        rst_in = 1'b1;
        stale = 1'b0;
        rdy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            stale |= out_valid;
            rdy |= in_ready;
        end
        chk("no_stale_beat", stale, 0);
        chk("not_ready_after_rst", rdy, 0);
        tick();
        load(rnd_vec(), rnd_vec(), rnd_vec(), 1, 0);
        send($urandom, $urandom, $urandom);
        send($urandom, $urandom, $urandom);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/barycentric_interp.md
# barycentric_interp

- Inverse of the barycentric solver: given a latched triangle (vertices `a`, `b`, `c`) and a stream of fixed-point weights (u, v, w), reconstructs `p = u*a + v*b + w*c` per component.
- Sits after the solver and rasterizer in the render path. It recovers world-space position or interpolates any per-vertex attribute vector for each accepted fragment.
- Fully pipelined, one result per cycle, with valid/ready flow control on both sides.

## Interface
Parameters:
- `COORD_WIDTH`, 32: signed fixed-point width. Format is Q(W/2).(W/2); FRAC = COORD_WIDTH/2.
- `N_ATTR`, 3: components per vertex/result.

Ports:
- `clk_in` input 1: the single clock.
- `rst_in` input 1: reset, asynchronous, active-low.
- `init` input 1: one-cycle request to load a new triangle.
- `a`, `b`, `c` input [N_ATTR-1:0][COORD_WIDTH-1:0] signed: vertex data. Must be held stable from `init` until `init_done`.
- `init_done` output 1: one-cycle pulse when the triangle is latched.
- `u`, `v`, `w` input [COORD_WIDTH-1:0] signed: weights for a, b, c.
- `in_valid` input 1 / `in_ready` output 1: input handshake.
- `p` output [N_ATTR-1:0][COORD_WIDTH-1:0] signed: result.
- `out_valid` output 1 / `out_ready` input 1: output handshake.
- `ovf` output 1: a component of `p` saturated (see Configuration).

## Operation
- States:
  - IDLE: no triangle loaded; `in_ready`=0.
  - DRAIN: init pending; waiting for the pipeline to empty; `in_ready`=0.
  - LOAD: latch `a`/`b`/`c` for one cycle; `in_ready`=0.
  - RUN: processing weights.
- Transitions:
  - IDLE --init--> LOAD.
  - RUN --init--> DRAIN if any stage is valid, else LOAD.
  - DRAIN --all stage valids 0--> LOAD.
  - LOAD --> RUN, pulsing `init_done`.
- `init` in DRAIN or LOAD is ignored. Vertices are sampled in the LOAD cycle.
- Per component i, per accepted beat:
  - S1: prod_a = u*a[i], prod_b = v*b[i], prod_c = w*c[i]; each is a 2W-bit signed product.
  - S2: sum in 2W+2 bits, then arithmetic shift right by FRAC (truncation toward −inf).
  - S3: reduce to W bits (wrap or saturate), register into `p`.
- No constraint that u+v+w = 1.0; the math is exact up to truncation.
- `in_ready` = (state==RUN) && !(out_valid && !out_ready). `in_ready` is combinational from `out_ready`.
- Global stall: when `out_valid && !out_ready`, every stage holds its data and valid bit.
- Order is preserved. No beats are dropped or duplicated.
- Reset (any time): all stage valids cleared, triangle discarded, state IDLE. Outputs reset to `p`=0, `out_valid`=0, `in_ready`=0, `init_done`=0, `ovf`=0.

## Timing
- Latency: a beat accepted at edge T gives `out_valid`=1 after edge T+3, absent stalls. Each stall cycle adds one.
- Throughput: 1 beat/cycle in RUN with `out_ready` held high.
- `init` at edge T from IDLE or empty RUN: LOAD at T+1, `init_done` pulse and RUN at T+2, first accept at T+2.
- From non-empty RUN: DRAIN lasts until the last in-flight beat completes its output handshake, then LOAD+1.
- `ovf` is aligned with the `p` beat it describes. It holds with `p` during a stall.
- Simultaneous `in_valid` and `init` in RUN: the beat is accepted if `in_ready`=1 and is computed with the old triangle. Then drain proceeds.

## Configuration
- `BARY_INTERP_SAT_EN`:
  - Defined: a component whose shifted sum exceeds the signed W-bit range clamps to 0x7FFF…F or 0x800…0, and `ovf`=1 for that beat.
  - Undefined: low W bits are taken (two's-complement wrap); `ovf` is tied 0.

## Structure
- Package `bary_pkg`:
  - default `COORD_WIDTH`
  - `FRAC_BITS`
  - `FP_ONE` (1.0 = 1<<FRAC)
  - the state enum typedef (IDLE, DRAIN, LOAD, RUN)
- Sub-module `bary_mac_lane`: one component, with three multipliers, the adder, the shift and the wrap/saturate stage. It takes the shared stall/valid, is instantiated N_ATTR times, and returns a per-lane ovf (ORed at top).
- The top module holds the FSM, vertex registers, valid shift chain and handshake.

## Test plan
- Load a=(0,0,0), b=(0x000A0000,0,0), c=(0,0x000A0000,0); wait `init_done`. Send (u,v,w)=(0x10000,0,0) -> p=(0,0,0). Send (0,0x8000,0x8000) -> p=(0x00050000,0x00050000,0), out_valid exactly 3 cycles after accept.
- Same triangle, 8 back-to-back beats, `out_ready`=1 -> 8 consecutive results, in order, one per cycle.
- Issue 4 beats, then drop `out_ready` for 5 cycles -> `in_ready`=0 during the stall, `p` held, all 4 results delivered in order with no loss or duplicate.
- `init` with 2 beats in flight and a new c=(0,0x00140000,0) -> both beats use the old c, `init_done` follows drain+LOAD, then (0,0,0x10000) -> p=(0,0x00140000,0).
- a=(0x7FFF0000,0,0), u=0x20000 -> with `BARY_INTERP_SAT_EN` p[0]=0x7FFFFFFF and ovf=1; without it p[0]=0xFFFE0000 and ovf=0.
- Assert `rst_in` low mid-stream -> all outputs 0 immediately, `in_ready`=0 until a new `init`; no stale beat emerges after release.
